// File: rtl/conv_result_writer.sv
// Result writer for a 2-D convolver.
// Collects one output frame of convolver results, which arrive in column-major
// order, into an internal RAM in raster order. It then presents the frame to a
// microcontroller one pixel per rising edge of the read strobe.
module conv_result_writer #(
  parameter int RAM_WIDTH    = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int KERNEL_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [RAM_WIDTH-1:0] i_data,
  input  logic                 i_read_valid,
  output logic                 o_frame_ready,
  output logic [RAM_WIDTH-1:0] o_data,
  output logic                 o_overrun
);

  // Number of bits needed to hold the value 'depth' (0 for depth == 0).
  function automatic int clogb2(input int depth);
    int v;
    int n;
    v = depth;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  localparam int OUT_W   = IMAGE_WIDTH - KERNEL_WIDTH + 1;
  localparam int OUT_H   = IMAGE_HEIGHT - KERNEL_WIDTH + 1;
  localparam int OUT_RES = OUT_W * OUT_H;
  localparam int AW      = (clogb2(OUT_RES - 1) > 0) ? clogb2(OUT_RES - 1) : 1;
  localparam int RW      = (clogb2(OUT_H - 1) > 0) ? clogb2(OUT_H - 1) : 1;
  localparam int CW      = (clogb2(OUT_W - 1) > 0) ? clogb2(OUT_W - 1) : 1;

  localparam logic [RW-1:0] ROW_LAST  = RW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(OUT_W - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(OUT_RES - 1);
  localparam logic [AW-1:0] OUT_W_A   = AW'(OUT_W);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    READOUT = 2'd1
  } state_t;

  state_t          state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [AW-1:0]   rd_addr;
  logic            rd_prev;
  logic            rd_rise;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   ram_addr;

  logic [RAM_WIDTH-1:0] ram [OUT_RES];

  // Results arrive column by column, but the RAM is laid out in raster order.
  assign wr_addr  = AW'(row) * OUT_W_A + AW'(col);
  // One port: the write address is used while collecting, the read address while reading out.
  assign ram_addr = (state == COLLECT) ? wr_addr : rd_addr;
  assign we       = (state == COLLECT) && i_valid;
  assign rd_rise  = i_read_valid && !rd_prev;

  // RAM write port. No reset, so the array can map to block RAM.
  always_ff @(posedge clk) begin
    if (we) ram[ram_addr] <= i_data;
  end

  // Registered read. Only updated in READOUT so that o_data holds its value while collecting.
  always_ff @(posedge clk) begin
    if (reset)                  o_data <= '0;
    else if (state == READOUT)  o_data <= ram[ram_addr];
  end

  // Control FSM: write counters, read address, strobe edge detect and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= COLLECT;
      row           <= '0;
      col           <= '0;
      rd_addr       <= '0;
      rd_prev       <= 1'b0;
      o_frame_ready <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      rd_prev <= i_read_valid;
      case (state)
        COLLECT: begin
          if (i_valid) begin
            if (row == ROW_LAST) begin
              row <= '0;
              if (col == COL_LAST) begin
                col           <= '0;
                rd_addr       <= '0;
                state         <= READOUT;
                o_frame_ready <= 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        READOUT: begin
          // Results that arrive while the frame is being read out are lost; flag them.
          if (i_valid) o_overrun <= 1'b1;
          if (rd_rise) begin
            if (rd_addr == ADDR_LAST) begin
              rd_addr       <= '0;
              state         <= COLLECT;
              o_frame_ready <= 1'b0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        default: begin
          state         <= COLLECT;
          row           <= '0;
          col           <= '0;
          rd_addr       <= '0;
          o_frame_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer at default parameters (8x8 output frame).
module tb_conv_result_writer;

  logic       clk;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_read_valid;
  logic       o_frame_ready;
  logic [7:0] o_data;
  logic       o_overrun;

  int pass_cnt  = 0;
  int check_cnt = 0;

  conv_result_writer dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_read_valid (i_read_valid),
    .o_frame_ready(o_frame_ready),
    .o_data       (o_data),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Address a = r*8+c holds the result that arrived at position c*8+r.
  function automatic logic [7:0] exp_pix(input int base, input int a);
    return 8'((base + (a % 8) * 8 + a / 8) % 256);
  endfunction

  task automatic write_frame(input int base, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 5));
        i_valid = 1'b0;
        repeat (g) tick();
      end
      i_valid = 1'b1;
      i_data  = 8'((base + k) % 256);
      tick();
    end
    i_valid = 1'b0;
  endtask

  // One rising edge on the strobe, then one idle cycle for the registered read.
  task automatic read_step();
    i_read_valid = 1'b1;
    tick();
    i_read_valid = 1'b0;
    tick();
  endtask

  // Read out the rest of the frame (addresses from..63) and check that the final edge closes it.
  task automatic read_rest(input string tag, input int base, input int from);
    for (int a = from; a < 64; a++) begin
      read_step();
      chk(tag, o_data, exp_pix(base, a));
    end
    i_read_valid = 1'b1;
    tick();
    chk({tag, "_end_ready"}, o_frame_ready, 0);
    i_read_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_read_valid = 1'b0;
    repeat (2) tick();
    chk("rst_ready", o_frame_ready, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_data", o_data, 0);
    reset = 1'b0;
    tick();

    // Frame A: 0..63 back to back, with a stray strobe edge while collecting.
    write_frame(0, 30, 1'b0);
    i_read_valid = 1'b1; tick(); i_read_valid = 1'b0; tick();
    write_frame(30, 33, 1'b0);
    chk("a_ready_before_last", o_frame_ready, 0);
    write_frame(63, 1, 1'b0);
    chk("a_ready_after_last", o_frame_ready, 1);
    tick();
    chk("a_pix0", o_data, exp_pix(0, 0));
    read_rest("a_pix", 0, 1);

    // Frame B: same values with random gaps; strobe held high advances once.
    write_frame(0, 64, 1'b1);
    chk("b_ready", o_frame_ready, 1);
    chk("b_overrun", o_overrun, 0);
    tick();
    chk("b_pix0", o_data, exp_pix(0, 0));
    i_read_valid = 1'b1;
    repeat (10) tick();
    i_read_valid = 1'b0;
    tick();
    chk("b_held_pix1", o_data, exp_pix(0, 1));
    read_rest("b_pix", 0, 2);

    // Frame C: 100..163; a result pulsed during readout is dropped and flagged.
    write_frame(100, 64, 1'b0);
    chk("c_ready", o_frame_ready, 1);
    i_valid = 1'b1; i_data = 8'hFF;
    tick();
    i_valid = 1'b0;
    chk("c_overrun", o_overrun, 1);
    chk("c_pix0", o_data, exp_pix(100, 0));
    read_rest("c_pix", 100, 1);
    chk("c_overrun_sticky", o_overrun, 1);

    // Reset part-way through a frame; the next frame starts again at address 0.
    write_frame(50, 20, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("r_overrun_clr", o_overrun, 0);
    chk("r_ready_clr", o_frame_ready, 0);
    write_frame(10, 63, 1'b0);
    chk("r_ready_63", o_frame_ready, 0);
    write_frame(73, 1, 1'b0);
    chk("r_ready_64", o_frame_ready, 1);
    tick();
    chk("r_pix0", o_data, exp_pix(10, 0));
    read_step();
    chk("r_pix1", o_data, exp_pix(10, 1));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
